// File: rtl/fifo_threshold.sv
// fifo_threshold: single-clock FIFO with programmable almost-empty / almost-full status.
// Define FIFO_ERR_STICKY_EN to hold error high from the first overflow/underflow until reset.
module fifo_threshold #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_WORD_SIZE = 10,
  parameter int unsigned FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  output logic [FIFO_PTR_SIZE:0]    count,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      error
);

  localparam logic [FIFO_PTR_SIZE:0]   DepthCnt = (FIFO_PTR_SIZE+1)'(FIFO_DEPTH);
  localparam logic [FIFO_PTR_SIZE:0]   CntOne   = (FIFO_PTR_SIZE+1)'(1);
  localparam logic [FIFO_PTR_SIZE-1:0] PtrOne   = FIFO_PTR_SIZE'(1);

  logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];

  logic [FIFO_PTR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_SIZE:0]    count_q, count_d;
  logic [FIFO_WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                      valid_q, valid_d;
  logic                      error_q, error_d;

  logic push_ok, pop_ok, reject;

  // Status is purely combinational on registered count and the live thresholds.
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DepthCnt);
  assign almost_empty = (count_q <= {1'b0, almost_empty_threshold});
  assign almost_full  = ((DepthCnt - count_q) <= {1'b0, almost_full_threshold});

  // A push into a full FIFO still lands when a pop frees the slot in the same edge.
  assign pop_ok  = pop && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);
  assign reject  = (push && !push_ok) || (pop && !pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PtrOne;
      data_out_d = mem[rd_ptr_q];
      valid_d    = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

`ifdef FIFO_ERR_STICKY_EN
    error_d = error_q || reject;
`else
    error_d = reject;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign count     = count_q;
  assign error     = error_q;

endmodule
